// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Builds 16-bit instructions for the bit-serial core from two 8-bit switch
// bytes, one button press per byte. The first press captures the high byte.
// The second press completes the instruction: opcode/instr update and
// inst_done pulses for one cycle.
//
// Optional feature: define LOADER_DEBOUNCE_EN to add a counter-based debounce
// filter on the synchronised button level. Without it, the filtered level is
// the synchronised level delayed by one register.
//
// Parameters
//   SYNC_STAGES      synchroniser depth on btn_raw and byte_in (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to accept a button
//                    level change (>= 1). Used only with LOADER_DEBOUNCE_EN.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   byte_in    in   [7:0] switch byte, asynchronous to clk
//   btn_raw    in   push button, active-high, asynchronous, may bounce
//   ld_clr     in   synchronous abort of a partially loaded instruction
//   opcode     out  [3:0]  opcode of the last completed instruction
//   instr      out  [11:0] operand field of the last completed instruction
//   inst_done  out  one-cycle strobe, opcode/instr just updated
//   btn_edge   out  one-cycle strobe per accepted button press
//   phase      out  0 = waiting for high byte, 1 = waiting for low byte
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        btn_raw,
  input  logic        ld_clr,
  output logic [3:0]  opcode,
  output logic [11:0] instr,
  output logic        inst_done,
  output logic        btn_edge,
  output logic        phase
);

  typedef enum logic {ST_HI = 1'b0, ST_LO = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [7:0]             byte_sync [SYNC_STAGES];
  logic                   btn_s;
  logic [7:0]             byte_s;
  logic                   btn_f;
  logic                   btn_rise;
  logic [7:0]             hold_hi;
  state_t                 state;

  // ---- stage: input synchronisers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) byte_sync[i] <= 8'h00;
    end else begin
      btn_sync     <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
      byte_sync[0] <= byte_in;
      for (int i = 1; i < SYNC_STAGES; i++) byte_sync[i] <= byte_sync[i-1];
    end
  end

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign byte_s = byte_sync[SYNC_STAGES-1];

  // ---- stage: button filter ----
`ifdef LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The change is taken on the DEBOUNCE_CYCLES-th consecutive cycle that
  // btn_s differs from btn_f; any return to agreement restarts the count.
  assign accept   = (btn_s != btn_f) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign btn_rise = accept && btn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      btn_f <= 1'b0;
    end else if (btn_s == btn_f) begin
      cnt <= '0;
    end else if (accept) begin
      btn_f <= btn_s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign btn_rise = btn_s && !btn_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_f <= 1'b0;
    else        btn_f <= btn_s;
  end
`endif

  // btn_edge is high in the same cycle btn_f first reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_edge <= 1'b0;
    else        btn_edge <= btn_rise;
  end

  // ---- stage: byte assembly FSM ----
  // ld_clr has priority over a coincident btn_edge: the byte is dropped, but
  // btn_edge itself has already gone out to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HI;
      phase     <= 1'b0;
      hold_hi   <= 8'h00;
      opcode    <= 4'h0;
      instr     <= 12'h000;
      inst_done <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      if (ld_clr) begin
        state <= ST_HI;
        phase <= 1'b0;
      end else if (btn_edge) begin
        case (state)
          ST_HI: begin
            hold_hi <= byte_s;
            state   <= ST_LO;
            phase   <= 1'b1;
          end
          ST_LO: begin
            opcode    <= hold_hi[7:4];
            instr     <= {hold_hi[3:0], byte_s};
            inst_done <= 1'b1;
            state     <= ST_HI;
            phase     <= 1'b0;
          end
          default: begin
            state <= ST_HI;
            phase <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int SYNC  = 2;
  localparam int DEBC  = 16;
`ifdef LOADER_DEBOUNCE_EN
  localparam bit DEB   = 1'b1;
  localparam int LAT   = SYNC + DEBC;
`else
  localparam bit DEB   = 1'b0;
  localparam int LAT   = SYNC + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        btn_raw;
  logic        ld_clr;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic        phase;

  instr_loader #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEBC)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .btn_raw(btn_raw),
    .ld_clr(ld_clr), .opcode(opcode), .instr(instr), .inst_done(inst_done),
    .btn_edge(btn_edge), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what the core should see, tracked per accepted press.
  logic [7:0]  m_hold;
  logic        m_phase;
  logic [3:0]  m_op;
  logic [11:0] m_ins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 8'h00; m_phase = 1'b0; m_op = 4'h0; m_ins = 12'h000;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_opcode"}, 32'(opcode), 32'(m_op));
    chk({tag, "_instr"},  32'(instr),  32'(m_ins));
    chk({tag, "_phase"},  32'(phase),  32'(m_phase));
  endtask

  // One button press: wait for the strobe, optionally abort on it, hold, release.
  task automatic do_press(input logic [7:0] b, input bit clr, input int hold);
    int  lat = 0;
    bit  got = 0;
    int  extra_e = 0;
    int  extra_d = 0;
    logic exp_done;
    @(negedge clk);
    byte_in = b;
    btn_raw = 1'b1;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (inst_done) extra_d++;
      if (btn_edge) begin got = 1; lat = k; break; end
    end
    chk("press_latency", got ? lat : 0, LAT);
    if (clr) ld_clr = 1'b1;
    byte_in = ~b;  // the byte must already have been captured from byte_s
    exp_done = 1'b0;
    if (clr) m_phase = 1'b0;
    else if (!m_phase) begin
      m_hold = b; m_phase = 1'b1;
    end else begin
      m_op = m_hold[7:4]; m_ins = {m_hold[3:0], b}; m_phase = 1'b0; exp_done = 1'b1;
    end
    @(negedge clk);
    ld_clr = 1'b0;
    chk("inst_done", 32'(inst_done), 32'(exp_done));
    chk("btn_edge_width", 32'(btn_edge), 0);
    chk_outputs("press");
    repeat (hold) begin
      @(negedge clk);
      if (btn_edge) extra_e++;
      if (inst_done) extra_d++;
    end
    btn_raw = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (btn_edge) extra_e++;
      if (inst_done) extra_d++;
    end
    chk("extra_btn_edge", extra_e, 0);
    chk("extra_inst_done", extra_d, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    ld_clr = 1'b1;
    @(negedge clk);
    ld_clr = 1'b0;
    m_phase = 1'b0;
    chk("clr_inst_done", 32'(inst_done), 0);
    chk_outputs("clr");
  endtask

  // Reset asserted away from any clock edge; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_inst_done", 32'(inst_done), 0);
    chk("rst_btn_edge", 32'(btn_edge), 0);
    chk("rst_phase", 32'(phase), 0);
    btn_raw = 1'b0;
    ld_clr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int          kind;   // 0 = press, 1 = standalone ld_clr
    logic [7:0]  b;
    bit          clr;    // ld_clr on the press's btn_edge cycle
    int          hold;
    logic [3:0]  op;
    logic [11:0] ins;
    logic        ph;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n_glitch;
    vecs[0] = '{0, 8'hA3, 1'b0, 2,   4'h0, 12'h000, 1'b1};
    vecs[1] = '{0, 8'h5C, 1'b0, 2,   4'hA, 12'h35C, 1'b0};
    vecs[2] = '{0, 8'h71, 1'b0, 3,   4'hA, 12'h35C, 1'b1};
    vecs[3] = '{1, 8'h00, 1'b0, 0,   4'hA, 12'h35C, 1'b0};
    vecs[4] = '{0, 8'h42, 1'b0, 200, 4'hA, 12'h35C, 1'b1};
    vecs[5] = '{0, 8'h99, 1'b0, 1,   4'h4, 12'h299, 1'b0};
    vecs[6] = '{0, 8'h12, 1'b0, 0,   4'h4, 12'h299, 1'b1};
    vecs[7] = '{0, 8'h34, 1'b1, 0,   4'h4, 12'h299, 1'b0};
    vecs[8] = '{0, 8'h56, 1'b0, 5,   4'h4, 12'h299, 1'b1};
    vecs[9] = '{0, 8'h78, 1'b0, 5,   4'h5, 12'h678, 1'b0};

    rst_n = 1'b0; byte_in = 8'h00; btn_raw = 1'b0; ld_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_opcode", 32'(opcode), 0);
    chk("init_instr", 32'(instr), 0);
    chk("init_inst_done", 32'(inst_done), 0);
    chk("init_btn_edge", 32'(btn_edge), 0);
    chk("init_phase", 32'(phase), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short glitch: filtered out only when debouncing is built in.
    n_glitch = 0;
    btn_raw = 1'b1;
    repeat (3) begin @(negedge clk); if (btn_edge) n_glitch++; end
    btn_raw = 1'b0;
    repeat (40) begin @(negedge clk); if (btn_edge) n_glitch++; end
    chk("glitch_edges", n_glitch, DEB ? 0 : 1);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].kind == 1) do_clear();
      else do_press(vecs[i].b, vecs[i].clr, vecs[i].hold);
      chk("vec_opcode", 32'(opcode), 32'(vecs[i].op));
      chk("vec_instr", 32'(instr), 32'(vecs[i].ins));
      chk("vec_phase", 32'(phase), 32'(vecs[i].ph));
    end

    // Reset while a high byte is pending; the next press is a high byte again.
    do_press(8'h11, 1'b0, 0);
    chk("midop_phase", 32'(phase), 1);
    do_reset();
    do_press(8'hFF, 1'b0, 0);
    do_press(8'h00, 1'b0, 0);
    chk("after_rst_opcode", 32'(opcode), 32'h0F);
    chk("after_rst_instr", 32'(instr), 32'hF00);

    // Random press / abort mix against the model.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) do_clear();
      else do_press(8'($urandom_range(0, 255)), r == 1, $urandom_range(0, 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
